param_modem: RTL
================

PARAM_MODEM -- requirements
Module: param_modem

Interface
REQ-001 Parameter OUT_W, default 7: sample width of mod_out.
REQ-002 Parameter PHASE_W, default 10: phase accumulator width; SHALL satisfy PHASE_W >= OUT_W+1.
REQ-003 Parameter SYM_LEN, default 32: clock cycles per symbol; SHALL be >= 2.
REQ-004 Parameters STEP_C, STEP0, STEP1, defaults 32, 32, 64: phase increment for carrier, FSK bit 0 and FSK bit 1.
REQ-005 Parameter FSK_THR, default 2: minimum carrier-cycle count per symbol that decodes as FSK bit 1.
REQ-006 clk  input  1  the single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 sel  input  2  mode: 00 ASK, 01 FSK, 10 BPSK, 11 QPSK.
REQ-009 data_in  input  2  symbol; bit 0 only for ASK/FSK/BPSK, both bits for QPSK.
REQ-010 data_valid  input  1  data_in valid.
REQ-011 data_ready  output  1  block accepts a symbol this cycle.
REQ-012 mod_out  output  OUT_W  registered, unsigned modulated sample.
REQ-013 demod_out  output  2  loopback-decoded symbol (bit 1 = 0 except in QPSK).
REQ-014 demod_valid  output  1  one-cycle pulse; demod_out updated.

Function
REQ-015 FSM states IDLE and ACTIVE; sym_cnt counts 0..SYM_LEN-1 in ACTIVE.
REQ-016 data_ready = 1 in IDLE, and in ACTIVE only when sym_cnt == SYM_LEN-1; 0 otherwise.
REQ-017 Accept = data_valid && data_ready; on accept, symbol and mode (sel) are latched, sym_cnt <= 0, state <= ACTIVE.
REQ-018 data_valid while data_ready = 0 is ignored; sel changes mid-symbol have no effect until the next accept.
REQ-019 ACTIVE, sym_cnt == SYM_LEN-1, no accept -> IDLE; phase accumulator <= 0.
REQ-020 Accept from IDLE starts with phase 0; accept at a symbol boundary keeps phase continuous (no reset, no gap cycle).
REQ-021 In ACTIVE, each cycle phase <= phase + step (mod 2^PHASE_W); step = STEP0/STEP1 per bit in FSK, STEP_C otherwise.
REQ-022 Modulated phase pm = phase + offset; offset = bit0<<(PHASE_W-1) in BPSK, data<<(PHASE_W-2) in QPSK, 0 otherwise.
REQ-023 Carrier sample c = pm[PHASE_W-1] ? ~pm[PHASE_W-2 -: OUT_W] : pm[PHASE_W-2 -: OUT_W] (triangle).
REQ-024 Sample = c>>2 for ASK bit 0, c in all other cases.
REQ-025 mod_out registers the sample of each ACTIVE cycle, appearing one cycle later; one cycle after IDLE is entered mod_out = 0.
REQ-026 Demod ASK: track max sample over the symbol; bit = max >= 2^(OUT_W-1).
REQ-027 Demod FSK: count cycles in the symbol where phase MSB goes 0->1 after increment; bit = count >= FSK_THR.
REQ-028 Demod BPSK/QPSK: coherent detector outputs (pm - phase)[PHASE_W-1 -: 2] at symbol end; BPSK uses its MSB as bit 0.
REQ-029 demod_out and demod_valid update in the cycle mod_out shows the symbol's last sample; demod_out holds until the next update.
REQ-030 Per-symbol demod accumulators clear at each accept.

Reset
REQ-031 On reset: state IDLE, sym_cnt 0, phase 0, latched symbol/mode 0, mod_out 0, demod_out 0, demod_valid 0; data_ready = 1 the cycle after.
REQ-032 Reset asserted mid-symbol aborts the symbol; no demod_valid is produced for it.

Verification
REQ-033 Reset, no data_valid -> mod_out 0, data_ready 1, demod_valid never pulses.
REQ-034 BPSK, bit 1 from IDLE -> first sample mod_out = 127, demod_valid after 32 samples with demod_out = 01; bit 0 -> first sample 0, demod_out = 00.
REQ-035 QPSK, data_in = 01 -> first sample 64, demod_out = 01; back-to-back 10 then 11 -> no gap, demod_out 10 then 11.
REQ-036 ASK bits 1,0 back-to-back -> symbol peaks 127 and 31, demod_out 01 then 00.
REQ-037 FSK bits 0,1 -> MSB rises 1 and 2 per symbol, demod_out 00 then 01; sel toggled mid-symbol has no effect.
REQ-038 Reset pulsed at sym_cnt 10 -> next cycle IDLE state, mod_out 0 after one cycle, no demod_valid.

Source files
------------

// File: rtl/param_modem.sv
// param_modem -- parameterised loopback modem (ASK / FSK / BPSK / QPSK).
//
// A phase accumulator drives a triangle carrier. Each accepted symbol lasts
// SYM_LEN cycles; the modulated sample of every active cycle is registered
// onto mod_out. A built-in detector decodes the same symbol and reports it
// on demod_out with a one-cycle demod_valid pulse. It fires in the cycle
// where mod_out shows the symbol's last sample.
//
// Ports
//   clk         in   single clock, rising edge
//   reset       in   synchronous, active-high reset
//   sel[1:0]    in   mode: 00 ASK, 01 FSK, 10 BPSK, 11 QPSK
//   data_in[1:0] in  symbol (bit 0 only, except QPSK uses both bits)
//   data_valid  in   data_in is valid
//   data_ready  out  a symbol is accepted this cycle if data_valid is high
//   mod_out     out  registered unsigned modulated sample, OUT_W bits
//   demod_out   out  decoded symbol (bit 1 is 0 except in QPSK)
//   demod_valid out  one-cycle pulse when demod_out updates
module param_modem #(
    parameter int OUT_W   = 7,
    parameter int PHASE_W = 10,
    parameter int SYM_LEN = 32,
    parameter int STEP_C  = 32,
    parameter int STEP0   = 32,
    parameter int STEP1   = 64,
    parameter int FSK_THR = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       sel,
    input  logic [1:0]       data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic [OUT_W-1:0] mod_out,
    output logic [1:0]       demod_out,
    output logic             demod_valid
);

    localparam int CNT_W = $clog2(SYM_LEN);
    localparam int FSK_W = $clog2(SYM_LEN + 1);
    localparam logic [CNT_W-1:0]   LAST   = CNT_W'(SYM_LEN - 1);
    localparam logic [PHASE_W-1:0] STEP_C_V = PHASE_W'(STEP_C);
    localparam logic [PHASE_W-1:0] STEP0_V  = PHASE_W'(STEP0);
    localparam logic [PHASE_W-1:0] STEP1_V  = PHASE_W'(STEP1);

    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef enum logic [1:0] {
        MODE_ASK  = 2'b00,
        MODE_FSK  = 2'b01,
        MODE_BPSK = 2'b10,
        MODE_QPSK = 2'b11
    } mode_t;

    state_t             state, state_next;
    mode_t              mode;
    logic [1:0]         sym;
    logic [CNT_W-1:0]   sym_cnt;
    logic [PHASE_W-1:0] phase, phase_next, step;
    logic [OUT_W:0]     offset_hi, pm_hi;
    logic [OUT_W-1:0]   carrier, sample;
    logic [OUT_W-1:0]   ask_max, ask_max_next;
    logic [FSK_W-1:0]   fsk_cnt, fsk_cnt_next;
    logic [1:0]         det, demod_bits;
    logic               is_last, accept, rise;

    assign is_last = (state == ACTIVE) && (sym_cnt == LAST);
    assign accept  = data_valid && data_ready;

    // ---------------- FSM: state register ----------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // ---------------- FSM: next state ----------------
    // NOTE: defaulting state_next first keeps this block free of latches.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACTIVE;
            ACTIVE:  if (is_last && !accept) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        data_ready = (state == IDLE) || is_last;
    end

    // ---------------- modulator / detector datapath ----------------
    always_comb begin
        step      = STEP_C_V;
        offset_hi = '0;
        case (mode)
            MODE_FSK:  step      = sym[0] ? STEP1_V : STEP0_V;
            MODE_BPSK: offset_hi = {sym[0], {OUT_W{1'b0}}};
            MODE_QPSK: offset_hi = {sym, {(OUT_W-1){1'b0}}};
            default:   ;
        endcase

        phase_next = phase + step;

        // The phase offset has no bits below the carrier slice, so only the
        // top OUT_W+1 phase bits take part in the modulated-phase sum.
        pm_hi   = phase[PHASE_W-1 -: OUT_W+1] + offset_hi;
        carrier = pm_hi[OUT_W] ? ~pm_hi[OUT_W-1:0] : pm_hi[OUT_W-1:0];
        sample  = (mode == MODE_ASK && !sym[0]) ? (carrier >> 2) : carrier;

        // The coherent reference is the unmodulated phase; the top two bits
        // of (pm - phase) recover the transmitted phase offset.
        det = pm_hi[OUT_W -: 2] - phase[PHASE_W-1 -: 2];

        rise         = !phase[PHASE_W-1] && phase_next[PHASE_W-1];
        ask_max_next = (sample > ask_max) ? sample : ask_max;
        fsk_cnt_next = fsk_cnt + FSK_W'(rise);

        // Include the current (last) sample so the decision is ready on the
        // same edge that registers it.
        case (mode)
            MODE_ASK:  demod_bits = {1'b0, ask_max_next[OUT_W-1]};
            MODE_FSK:  demod_bits = {1'b0, 32'(fsk_cnt_next) >= $unsigned(FSK_THR)};
            MODE_BPSK: demod_bits = {1'b0, det[1]};
            default:   demod_bits = det;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sym_cnt     <= '0;
            phase       <= '0;
            sym         <= '0;
            mode        <= MODE_ASK;
            mod_out     <= '0;
            demod_out   <= '0;
            demod_valid <= 1'b0;
            ask_max     <= '0;
            fsk_cnt     <= '0;
        end else begin
            demod_valid <= 1'b0;

            if (accept) begin
                sym     <= data_in;
                mode    <= mode_t'(sel);
                sym_cnt <= '0;
                ask_max <= '0;
                fsk_cnt <= '0;
            end else if (is_last) begin
                sym_cnt <= '0;
            end else if (state == ACTIVE) begin
                sym_cnt <= sym_cnt + CNT_W'(1);
                ask_max <= ask_max_next;
                fsk_cnt <= fsk_cnt_next;
            end

            // Phase runs on across back-to-back symbols and restarts at 0
            // whenever the block falls back to IDLE.
            if (state == ACTIVE && !(is_last && !accept)) phase <= phase_next;
            else                                           phase <= '0;

            mod_out <= (state == ACTIVE) ? sample : '0;

            if (is_last) begin
                demod_out   <= demod_bits;
                demod_valid <= 1'b1;
            end
        end
    end

endmodule
